lut_dump_fsm_stream: RTL

Readback streamer for the segment LUT. On a dump request it walks every LUT entry and reads the (base, slope) pair from lut_core. It emits each pair as a 16-bit word stream, base first, then slope, under a valid/ready handshake. The word order matches the configuration stream exactly, so a dump can be fed straight back into the LUT configuration FSM, or compared against the loaded image, for checking and debug.

---
 rtl/lut_dump_fsm_stream.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lut_dump_fsm_stream.sv
// Segment LUT readback streamer.
// Walks every LUT entry, reads its (base, slope) pair and emits the two values
// as a 16-bit word stream (base first, then slope) under valid/ready, so the
// dump has the same word order as the configuration stream.
module lut_dump_fsm_stream #(
    parameter int SEG_BITS  = 8,
    parameter int LUT_DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dump_mode,
    output logic                       rd_en,
    output logic [SEG_BITS-1:0]        rd_addr,
    input  logic signed [15:0]         rd_base,
    input  logic signed [15:0]         rd_slope,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic signed [15:0]         dout,
    output logic                       dump_done,
    output logic                       dump_busy,
    output logic                       dumped,
    output logic [SEG_BITS-1:0]        ptr_dbg,
    output logic [2:0]                 state_dbg
);

    localparam logic [SEG_BITS-1:0] LAST    = SEG_BITS'(LUT_DEPTH - 1);
    localparam logic [SEG_BITS-1:0] PTR_ONE = SEG_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WAIT   = 3'd2,
        S_SEND_B = 3'd3,
        S_SEND_S = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [SEG_BITS-1:0]       ptr_q, ptr_d;
    logic signed [15:0]        base_hold_q, base_hold_d;
    logic signed [15:0]        slope_hold_q, slope_hold_d;
    logic                      dumped_q, dumped_d;
    logic                      dump_mode_dly_q;
    logic                      dump_start;

    // Only a fresh rising edge of dump_mode may start a dump; a held level never re-triggers.
    assign dump_start = dump_mode & ~dump_mode_dly_q;

    // State and datapath registers; reset forces IDLE so every output drops immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            base_hold_q     <= '0;
            slope_hold_q    <= '0;
            dumped_q        <= 1'b0;
            dump_mode_dly_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            base_hold_q     <= base_hold_d;
            slope_hold_q    <= slope_hold_d;
            dumped_q        <= dumped_d;
            dump_mode_dly_q <= dump_mode;
        end
    end

    // Next-state and output decode; dropping dump_mode in any busy state aborts,
    // and the abort wins over completion of the final slope word.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        base_hold_d  = base_hold_q;
        slope_hold_d = slope_hold_q;
        dumped_d     = dumped_q;
        rd_en        = 1'b0;
        dout_valid   = 1'b0;
        dout         = '0;
        dump_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    state_d  = S_READ;
                    ptr_d    = '0;
                    dumped_d = 1'b0;
                end
            end
            S_READ: begin
                rd_en = 1'b1;
                if (!dump_mode) state_d = S_IDLE;
                else            state_d = S_WAIT;
            end
            S_WAIT: begin
                // LUT read data is valid this cycle; capture it for the two send states.
                if (!dump_mode) begin
                    state_d = S_IDLE;
                end else begin
                    base_hold_d  = rd_base;
                    slope_hold_d = rd_slope;
                    state_d      = S_SEND_B;
                end
            end
            S_SEND_B: begin
                dout_valid = 1'b1;
                dout       = base_hold_q;
                if (!dump_mode)      state_d = S_IDLE;
                else if (dout_ready) state_d = S_SEND_S;
            end
            S_SEND_S: begin
                dout_valid = 1'b1;
                dout       = slope_hold_q;
                if (!dump_mode) begin
                    state_d = S_IDLE;
                end else if (dout_ready) begin
                    if (ptr_q == LAST) begin
                        dump_done = 1'b1;
                        dumped_d  = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        // Increment is never applied at LAST, so the pointer cannot wrap.
                        ptr_d   = ptr_q + PTR_ONE;
                        state_d = S_READ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_addr   = ptr_q;
    assign ptr_dbg   = ptr_q;
    assign state_dbg = state_q;
    assign dump_busy = (state_q != S_IDLE);
    assign dumped    = dumped_q;

endmodule
